pipe_ctrl: RTL and testbench

Pipeline control unit for the 6-stage in-order core. Collects stall requests from the IF, ID, EX and MEM stages, and redirect requests from EX (branch mispredict) and MEM (exception/trap commit). Drives the per-stage stall vector and the flush signals consumed by every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb), plus the redirect PC to the fetch unit. Contains a flush-sequencing FSM and a stall watchdog.

---
 rtl/pipe_ctrl_if.sv | 43 ++++
 rtl/pipe_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_if
//  Description : Stall/redirect bundle between the pipeline stages and the
//                pipeline control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
    // Requests from the pipeline stages
    logic        stallreq_if_i;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic        stallreq_mem_i;
    logic        branch_redirect_i;
    logic [31:0] branch_pc_i;
    logic        exception_i;
    logic [31:0] trap_pc_i;

    // Controls back to the pipeline registers and the fetch unit
    logic [5:0]  stall_o;
    logic        flush_o;
    logic        flush_fe_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        hang_o;

    // Pipeline side: raises requests, consumes controls
    modport master (
        output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output branch_redirect_i, branch_pc_i, exception_i, trap_pc_i,
        input  stall_o, flush_o, flush_fe_o, redirect_valid_o, redirect_pc_o,
        input  hang_o
    );

    // Control unit side
    modport slave (
        input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  branch_redirect_i, branch_pc_i, exception_i, trap_pc_i,
        output stall_o, flush_o, flush_fe_o, redirect_valid_o, redirect_pc_o,
        output hang_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Pipeline control for the 6-stage in-order core. Builds the
//                per-stage stall vector, sequences flushes after traps and
//                branch mispredicts, drives the fetch redirect and runs a
//                stall watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int FLUSH_CYCLES  = 1,     // flush_o length after a trap (1..15)
    parameter int STALL_TIMEOUT = 1023   // stall cycles before hang_o (<= 16 bits)
) (
    input  wire logic clk_i,
    input  wire logic n_rst_i,
    pipe_ctrl_if.slave bus
);

    // FSM encoding
    localparam logic [0:0] c_S_RUN   = 1'b0;
    localparam logic [0:0] c_S_FLUSH = 1'b1;

    localparam logic [3:0]  c_FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);
    localparam logic        c_MULTI_FLUSH = (FLUSH_CYCLES > 1);
    localparam logic [15:0] c_TIMEOUT     = 16'(STALL_TIMEOUT);

    // Stall patterns: the requesting stage freezes itself and everything older
    localparam logic [5:0] c_STALL_MEM  = 6'b011111;
    localparam logic [5:0] c_STALL_EX   = 6'b001111;
    localparam logic [5:0] c_STALL_ID   = 6'b000111;
    localparam logic [5:0] c_STALL_IF   = 6'b000011;
    localparam logic [5:0] c_STALL_NONE = 6'b000000;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [3:0]  r_flush_cnt;
    logic [3:0]  w_flush_cnt_nxt;

    logic        r_flush;
    logic        r_flush_fe;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;
    logic        w_flush_nxt;
    logic        w_flush_fe_nxt;
    logic        w_redirect_valid_nxt;
    logic [31:0] w_redirect_pc_nxt;

    logic [15:0] r_wd_cnt;
    logic        r_hang;

    logic [5:0]  w_stall_req;
    logic [5:0]  w_stall;
    logic        w_exc_take;
    logic        w_br_take;

    // A trap is only taken while running; a mispredict additionally waits
    // until neither EX nor MEM is holding the pipe.
    assign w_exc_take = (r_state == c_S_RUN) && bus.exception_i;
    assign w_br_take  = (r_state == c_S_RUN) && bus.branch_redirect_i &&
                        !bus.exception_i && !bus.stallreq_mem_i &&
                        !bus.stallreq_ex_i;

    // Stall priority: the youngest requesting stage decides the pattern
    always_comb begin
        w_stall_req = c_STALL_NONE;
        if (bus.stallreq_mem_i) begin
            w_stall_req = c_STALL_MEM;
        end else if (bus.stallreq_ex_i) begin
            w_stall_req = c_STALL_EX;
        end else if (bus.stallreq_id_i) begin
            w_stall_req = c_STALL_ID;
        end else if (bus.stallreq_if_i) begin
            w_stall_req = c_STALL_IF;
        end
    end

    // A flush must never be blocked by a stall; also quiet while in reset
    assign w_stall = (!n_rst_i || bus.exception_i || (r_state == c_S_FLUSH))
                   ? c_STALL_NONE : w_stall_req;

    // FSM state and flush counter register
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_state     <= c_S_RUN;
            r_flush_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // FSM next state: a trap loads the counter, S_FLUSH counts it down
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            c_S_RUN: begin
                if (w_exc_take) begin
                    w_flush_cnt_nxt = c_FLUSH_LOAD;
                    if (c_MULTI_FLUSH) begin
                        w_state_nxt = c_S_FLUSH;
                    end
                end
            end
            c_S_FLUSH: begin
                if (r_flush_cnt == 4'd0) begin
                    w_state_nxt = c_S_RUN;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt     = c_S_RUN;
                w_flush_cnt_nxt = 4'd0;
            end
        endcase
    end

    // FSM outputs: next values of the registered flush/redirect controls
    always_comb begin
        w_flush_nxt          = 1'b0;
        w_flush_fe_nxt       = 1'b0;
        w_redirect_valid_nxt = 1'b0;
        w_redirect_pc_nxt    = r_redirect_pc;
        case (r_state)
            c_S_RUN: begin
                if (w_exc_take) begin
                    w_flush_nxt          = 1'b1;
                    w_redirect_valid_nxt = 1'b1;
                    w_redirect_pc_nxt    = bus.trap_pc_i;
                end else if (w_br_take) begin
                    w_flush_fe_nxt       = 1'b1;
                    w_redirect_valid_nxt = 1'b1;
                    w_redirect_pc_nxt    = bus.branch_pc_i;
                end
            end
            c_S_FLUSH: begin
                // Still flushing unless this is the last counted cycle
                w_flush_nxt = (r_flush_cnt != 4'd0);
            end
            default: begin
                w_flush_nxt = 1'b0;
            end
        endcase
    end

    // Registered flush/redirect outputs (one cycle after acceptance)
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_flush          <= 1'b0;
            r_flush_fe       <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
        end else begin
            r_flush          <= w_flush_nxt;
            r_flush_fe       <= w_flush_fe_nxt;
            r_redirect_valid <= w_redirect_valid_nxt;
            r_redirect_pc    <= w_redirect_pc_nxt;
        end
    end

    // Watchdog: count consecutive PC-stall cycles, saturating at the timeout
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_wd_cnt <= 16'd0;
        end else if (!w_stall[0]) begin
            r_wd_cnt <= 16'd0;
        end else if (r_wd_cnt != c_TIMEOUT) begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
        end
    end

    // Sticky hang flag once the stall outlives the timeout
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_hang <= 1'b0;
        end else if (w_stall[0] && (r_wd_cnt == c_TIMEOUT)) begin
            r_hang <= 1'b1;
        end
    end

    assign bus.stall_o          = w_stall;
    assign bus.flush_o          = r_flush;
    assign bus.flush_fe_o       = r_flush_fe;
    assign bus.redirect_valid_o = r_redirect_valid;
    assign bus.redirect_pc_o    = r_redirect_pc;
    assign bus.hang_o           = r_hang;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Self-checking bench for pipe_ctrl. Two instances share one
//                stimulus: A with FLUSH_CYCLES=1, B with FLUSH_CYCLES=3, both
//                with STALL_TIMEOUT=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int T_OUT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        s_if, s_id, s_ex, s_mem, br, exc;
    logic [31:0] bpc, tpc;

    int total = 0;
    int bad   = 0;

    pipe_ctrl_if ifa ();
    pipe_ctrl_if ifb ();

    assign ifa.stallreq_if_i = s_if;   assign ifb.stallreq_if_i = s_if;
    assign ifa.stallreq_id_i = s_id;   assign ifb.stallreq_id_i = s_id;
    assign ifa.stallreq_ex_i = s_ex;   assign ifb.stallreq_ex_i = s_ex;
    assign ifa.stallreq_mem_i = s_mem; assign ifb.stallreq_mem_i = s_mem;
    assign ifa.branch_redirect_i = br; assign ifb.branch_redirect_i = br;
    assign ifa.branch_pc_i = bpc;      assign ifb.branch_pc_i = bpc;
    assign ifa.exception_i = exc;      assign ifb.exception_i = exc;
    assign ifa.trap_pc_i = tpc;        assign ifb.trap_pc_i = tpc;

    pipe_ctrl #(.FLUSH_CYCLES(1), .STALL_TIMEOUT(T_OUT)) dut_a (
        .clk_i(clk), .n_rst_i(rst_n), .bus(ifa.slave));
    pipe_ctrl #(.FLUSH_CYCLES(3), .STALL_TIMEOUT(T_OUT)) dut_b (
        .clk_i(clk), .n_rst_i(rst_n), .bus(ifb.slave));

    logic [5:0]  d_stall [2];
    logic        d_flush [2], d_fe [2], d_rv [2], d_hang [2];
    logic [31:0] d_pc [2];
    assign d_stall[0] = ifa.stall_o;          assign d_stall[1] = ifb.stall_o;
    assign d_flush[0] = ifa.flush_o;          assign d_flush[1] = ifb.flush_o;
    assign d_fe[0]    = ifa.flush_fe_o;       assign d_fe[1]    = ifb.flush_fe_o;
    assign d_rv[0]    = ifa.redirect_valid_o; assign d_rv[1]    = ifb.redirect_valid_o;
    assign d_pc[0]    = ifa.redirect_pc_o;    assign d_pc[1]    = ifb.redirect_pc_o;
    assign d_hang[0]  = ifa.hang_o;           assign d_hang[1]  = ifb.hang_o;

    // ---------------- behavioural model ----------------
    // m_fcnt: flush cycles still owed (including the current one)
    // m_run : consecutive cycles so far with the PC stalled
    int          m_fcnt [2];
    int          m_run  [2];
    logic        m_flush [2], m_fe [2], m_rv [2], m_hang [2];
    logic [31:0] m_pc [2];

    function automatic int fc(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Inputs are ignored while a multi-cycle flush is in progress
    function automatic logic busy(input int k);
        return (m_fcnt[k] > 0) && (fc(k) > 1);
    endfunction

    function automatic logic [5:0] exp_stall(input int k);
        if (!rst_n || exc || busy(k)) return 6'b000000;
        if (s_mem) return 6'b011111;
        if (s_ex)  return 6'b001111;
        if (s_id)  return 6'b000111;
        if (s_if)  return 6'b000011;
        return 6'b000000;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic       bz;
        logic [5:0] es;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_fcnt[k] <= 0; m_run[k] <= 0;
                m_flush[k] <= 1'b0; m_fe[k] <= 1'b0; m_rv[k] <= 1'b0;
                m_pc[k] <= 32'd0; m_hang[k] <= 1'b0;
            end else begin
                bz = busy(k);
                es = exp_stall(k);
                if (es[0] && (m_run[k] >= T_OUT)) m_hang[k] <= 1'b1;
                m_run[k] <= es[0] ? m_run[k] + 1 : 0;
                if (!bz && exc) begin
                    m_fcnt[k] <= fc(k);
                    m_flush[k] <= 1'b1; m_fe[k] <= 1'b0; m_rv[k] <= 1'b1;
                    m_pc[k] <= tpc;
                end else if (!bz && br && !s_mem && !s_ex) begin
                    m_fcnt[k] <= 0;
                    m_flush[k] <= 1'b0; m_fe[k] <= 1'b1; m_rv[k] <= 1'b1;
                    m_pc[k] <= bpc;
                end else begin
                    m_fcnt[k] <= (m_fcnt[k] > 0) ? m_fcnt[k] - 1 : 0;
                    m_flush[k] <= (m_fcnt[k] > 1);
                    m_fe[k] <= 1'b0; m_rv[k] <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d stall", k), 32'(d_stall[k]), 32'(exp_stall(k)));
            check($sformatf("dut%0d flush", k), 32'(d_flush[k]), 32'(m_flush[k]));
            check($sformatf("dut%0d flush_fe", k), 32'(d_fe[k]), 32'(m_fe[k]));
            check($sformatf("dut%0d redirect_valid", k), 32'(d_rv[k]), 32'(m_rv[k]));
            check($sformatf("dut%0d redirect_pc", k), d_pc[k], m_pc[k]);
            check($sformatf("dut%0d hang", k), 32'(d_hang[k]), 32'(m_hang[k]));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        rst_n = 1'b0;
        s_if = 0; s_id = 0; s_ex = 0; s_mem = 0; br = 0; exc = 0;
        bpc = 32'd0; tpc = 32'd0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("lit reset stall", 32'(ifa.stall_o), 32'd0);
        check("lit reset flush", 32'(ifa.flush_o), 32'd0);
        check("lit reset rv", 32'(ifa.redirect_valid_o), 32'd0);
        check("lit reset hang", 32'(ifa.hang_o), 32'd0);
        check("lit reset pc", ifa.redirect_pc_o, 32'd0);

        // Stall priority: mem beats id, dropping mem takes effect same cycle
        next_cycle();
        s_id = 1; s_mem = 1;
        @(negedge clk);
        check("lit stall id+mem", 32'(ifa.stall_o), 32'h1f);
        s_mem = 0;
        #1 check("lit stall id only", 32'(ifa.stall_o), 32'h07);
        check("lit stall id only b", 32'(ifb.stall_o), 32'h07);
        next_cycle();
        s_id = 0;

        // Trap while MEM stalls: stall suppressed, then flush sequence
        exc = 1; tpc = 32'h0000_0100; s_mem = 1;
        #1 check("lit exc stall a", 32'(ifa.stall_o), 32'd0);
        check("lit exc stall b", 32'(ifb.stall_o), 32'd0);
        next_cycle();
        exc = 0; s_mem = 0;
        @(negedge clk);
        check("lit trap flush a", 32'(ifa.flush_o), 32'd1);
        check("lit trap rv a", 32'(ifa.redirect_valid_o), 32'd1);
        check("lit trap pc a", ifa.redirect_pc_o, 32'h0000_0100);
        check("lit trap fe a", 32'(ifa.flush_fe_o), 32'd0);
        check("lit trap flush b", 32'(ifb.flush_o), 32'd1);
        check("lit trap rv b", 32'(ifb.redirect_valid_o), 32'd1);
        next_cycle();
        br = 1; bpc = 32'h0000_0200;   // arrives mid-flush for B
        @(negedge clk);
        check("lit post flush a", 32'(ifa.flush_o), 32'd0);
        check("lit post rv a", 32'(ifa.redirect_valid_o), 32'd0);
        check("lit flush2 b", 32'(ifb.flush_o), 32'd1);
        check("lit flush2 rv b", 32'(ifb.redirect_valid_o), 32'd0);
        next_cycle();
        br = 0;
        @(negedge clk);
        check("lit flush3 b", 32'(ifb.flush_o), 32'd1);
        check("lit flush3 fe b", 32'(ifb.flush_fe_o), 32'd0);
        check("lit branch fe a", 32'(ifa.flush_fe_o), 32'd1);
        check("lit branch pc a", ifa.redirect_pc_o, 32'h0000_0200);
        next_cycle();
        @(negedge clk);
        check("lit flush end b", 32'(ifb.flush_o), 32'd0);
        check("lit ignored br pc b", ifb.redirect_pc_o, 32'h0000_0100);
        check("lit ignored br rv b", 32'(ifb.redirect_valid_o), 32'd0);

        // Mispredict held off by an EX stall
        next_cycle();
        br = 1; bpc = 32'h8000_0040; s_ex = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("lit held rv", 32'(ifa.redirect_valid_o), 32'd0);
            next_cycle();
        end
        s_ex = 0;
        @(negedge clk);
        check("lit held rv last", 32'(ifa.redirect_valid_o), 32'd0);
        next_cycle();
        br = 0;
        @(negedge clk);
        check("lit br fe", 32'(ifa.flush_fe_o), 32'd1);
        check("lit br rv", 32'(ifa.redirect_valid_o), 32'd1);
        check("lit br pc", ifa.redirect_pc_o, 32'h8000_0040);
        check("lit br flush", 32'(ifa.flush_o), 32'd0);
        check("lit br fe b", 32'(ifb.flush_fe_o), 32'd1);

        // Watchdog: IF request held 10 cycles
        next_cycle();
        s_if = 1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check($sformatf("lit hang cyc%0d", c), 32'(ifa.hang_o), (c >= 10) ? 32'd1 : 32'd0);
            next_cycle();
        end
        s_if = 0;
        repeat (3) begin
            @(negedge clk);
            check("lit hang sticky", 32'(ifa.hang_o), 32'd1);
            next_cycle();
        end

        // Asynchronous reset in the middle of B's flush
        exc = 1; tpc = 32'h0000_0300;
        next_cycle();
        exc = 0; s_mem = 1;
        #1 rst_n = 1'b0;
        #1 check("lit rst flush b", 32'(ifb.flush_o), 32'd0);
        check("lit rst rv b", 32'(ifb.redirect_valid_o), 32'd0);
        check("lit rst pc b", ifb.redirect_pc_o, 32'd0);
        check("lit rst stall b", 32'(ifb.stall_o), 32'd0);
        check("lit rst hang a", 32'(ifa.hang_o), 32'd0);
        next_cycle();
        rst_n = 1'b1; s_mem = 0;
        repeat (2) begin
            @(negedge clk);
            check("lit after rst rv b", 32'(ifb.redirect_valid_o), 32'd0);
            check("lit after rst flush b", 32'(ifb.flush_o), 32'd0);
            next_cycle();
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
